// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - two-digit BCD up/down timer with prescaler and IDLE/RUN/DONE control
//
// Counts a two-digit BCD value (tens:ones, 00..99) once every PRESCALE clocks
// while in RUN. lever selects the direction, sampled only on the tick edge.
// WRAP=1 wraps at the limits; WRAP=0 holds the digits and enters DONE.
//
// Optional build macro: BCD_TIMER_LEVER_SYNC_EN
//   defined   - lever passes through a two-flop synchronizer (reset value 1)
//   undefined - lever is used directly
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin/resume counting (ignored while in RUN)
//   stop     in   pause counting, digits and prescaler hold
//   clear    in   zero the digits and return to IDLE
//   lever    in   direction, 1 = up, 0 = down
//   ones     out  BCD ones digit
//   tens     out  BCD tens digit
//   running  out  high in RUN
//   done     out  high in DONE
//   tc       out  one-cycle terminal-count pulse
module bcd_timer_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter bit          WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lever,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);

  state_t     state_q, state_d;
  logic [7:0] psc_q, psc_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       tc_q, tc_d;
  logic       dir;

`ifdef BCD_TIMER_LEVER_SYNC_EN
  logic lever_s1, lever_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lever_s1 <= 1'b1;
      lever_s2 <= 1'b1;
    end else begin
      lever_s1 <= lever;
      lever_s2 <= lever_s1;
    end
  end

  assign dir = lever_s2;
`else
  assign dir = lever;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      psc_q   <= 8'd0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    tc_d    = 1'b0;

    if (clear) begin
      state_d = IDLE;
      psc_d   = 8'd0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else if (stop) begin
      // stop outranks start, so a stop outside RUN simply blocks a start
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      psc_d   = 8'd0;
    end else if (state_q == RUN) begin
      if (psc_q == PSC_LAST) begin
        psc_d = 8'd0;
        if (dir) begin
          if (tens_q == 4'd9 && ones_q == 4'd9) begin
            tc_d = 1'b1;
            if (WRAP) begin
              ones_d = 4'd0;
              tens_d = 4'd0;
            end else begin
              state_d = DONE;
            end
          end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          if (tens_q == 4'd0 && ones_q == 4'd0) begin
            tc_d = 1'b1;
            if (WRAP) begin
              ones_d = 4'd9;
              tens_d = 4'd9;
            end else begin
              state_d = DONE;
            end
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end else begin
        psc_d = psc_q + 8'd1;
      end
    end
  end

  assign ones    = ones_q;
  assign tens    = tens_q;
  assign tc      = tc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb/tb_bcd_timer_ctrl.sv - self-checking bench for bcd_timer_ctrl (three parameter sets)
module tb_bcd_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lever = 1'b1;
  logic [3:0] ones_o [3];
  logic [3:0] tens_o [3];
  logic       running_o [3];
  logic       done_o [3];
  logic       tc_o [3];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // instance 0: PRESCALE=4 WRAP=1, instance 1: PRESCALE=3 WRAP=0, instance 2: PRESCALE=1 WRAP=1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_timer_ctrl #(
      .PRESCALE((g == 0) ? 4 : (g == 1) ? 3 : 1),
      .WRAP    ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .clear  (clear),
      .lever  (lever),
      .ones   (ones_o[g]),
      .tens   (tens_o[g]),
      .running(running_o[g]),
      .done   (done_o[g]),
      .tc     (tc_o[g])
    );
  end

  // reference model: count held as an integer 0..99, state 0=IDLE 1=RUN 2=DONE
  int m_ps [3];
  bit m_wr [3];
  int m_st [3];
  int m_val[3];
  int m_psc[3];
  bit m_tc [3];
  bit m_l1 [3];
  bit m_l2 [3];

  function automatic logic [10:0] got(int k);
    return {tens_o[k], ones_o[k], running_o[k], done_o[k], tc_o[k]};
  endfunction

  function automatic logic [10:0] expv(int k);
    return {4'(m_val[k] / 10), 4'(m_val[k] % 10), m_st[k] == 1, m_st[k] == 2, m_tc[k]};
  endfunction

  function automatic logic [10:0] pack(int t, int o, logic r, logic d, logic c);
    return {4'(t), 4'(o), r, d, c};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got tens=%0d ones=%0d run=%0b done=%0b tc=%0b, want tens=%0d ones=%0d run=%0b done=%0b tc=%0b",
               name, act[10:7], act[6:3], act[2], act[1], act[0],
               req[10:7], req[6:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_val[k] = 0; m_psc[k] = 0; m_tc[k] = 0;
      m_l1[k] = 1; m_l2[k] = 1;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input bit l);
    bit eff;
    for (int k = 0; k < 3; k++) begin
`ifdef BCD_TIMER_LEVER_SYNC_EN
      eff = m_l2[k];
      m_l2[k] = m_l1[k];
      m_l1[k] = l;
`else
      eff = l;
`endif
      m_tc[k] = 0;
      if (c) begin
        m_val[k] = 0; m_psc[k] = 0; m_st[k] = 0;
      end else if (p) begin
        if (m_st[k] == 1) m_st[k] = 0;
      end else if (s && m_st[k] != 1) begin
        m_st[k] = 1; m_psc[k] = 0;
      end else if (m_st[k] == 1) begin
        if (m_psc[k] == m_ps[k] - 1) begin
          m_psc[k] = 0;
          if (eff ? (m_val[k] == 99) : (m_val[k] == 0)) begin
            m_tc[k] = 1;
            if (m_wr[k]) m_val[k] = eff ? 0 : 99;
            else m_st[k] = 2;
          end else begin
            m_val[k] = eff ? m_val[k] + 1 : m_val[k] - 1;
          end
        end else begin
          m_psc[k]++;
        end
      end
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit c, input bit l);
    start = s; stop = p; clear = c; lever = l;
    @(posedge clk);
    model_step(s, p, c, l);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("model[%0d]", k), got(k), expv(k));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("async_rst[%0d]", k), got(k), 11'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s, p, c, l;
    int t, o;
    bit r, d, tc;
  } vec_t;

  vec_t tbl[19];

  initial begin
    m_ps = '{4, 3, 1};
    m_wr = '{1'b1, 1'b0, 1'b1};
    model_reset();

    // expectations for instance 0 (PRESCALE=4, WRAP=1), starting from reset
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 2, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 2, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 0, 2, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 2, 1, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 9, 9, 1, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 9, 9, 1, 0, 0};

    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("reset[%0d]", k), got(k), 11'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l);
      chk($sformatf("tbl[%0d]", i), got(0),
          pack(tbl[i].t, tbl[i].o, tbl[i].r, tbl[i].d, tbl[i].tc));
    end

    // count up to 99 then wrap to 00 with a single tc cycle, then wrap down
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 396; i++) cyc(0, 0, 0, 1);
    chk("up_to_99", got(0), pack(9, 9, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("hold_99", got(0), pack(9, 9, 1, 0, 0));
    cyc(0, 0, 0, 1);
    chk("wrap_up_00", got(0), pack(0, 0, 1, 0, 1));
    cyc(0, 0, 0, 1);
    chk("wrap_up_tc_off", got(0), pack(0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("wrap_down_99", got(0), pack(9, 9, 1, 0, 1));

    // saturating instance: down 01 -> 00 -> DONE, then restart re-enters DONE
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("sat_01", got(1), pack(0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("sat_00", got(1), pack(0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("sat_done", got(1), pack(0, 0, 0, 1, 1));
    cyc(0, 0, 0, 0);
    chk("sat_done_hold", got(1), pack(0, 0, 0, 1, 0));
    cyc(1, 0, 0, 0);
    chk("sat_restart", got(1), pack(0, 0, 1, 0, 0));
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
    chk("sat_restart_run", got(1), pack(0, 0, 1, 0, 0));
    cyc(0, 0, 0, 0);
    chk("sat_redone", got(1), pack(0, 0, 0, 1, 1));

    // PRESCALE=1 instance: reach 37, stop holds, start resumes
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 37; i++) cyc(0, 0, 0, 1);
    chk("p1_37", got(2), pack(3, 7, 1, 0, 0));
    cyc(0, 1, 0, 1);
    chk("stop_37", got(2), pack(3, 7, 0, 0, 0));
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("stop_hold_37", got(2), pack(3, 7, 0, 0, 0));
    cyc(1, 0, 0, 1);
    chk("resume_37", got(2), pack(3, 7, 1, 0, 0));
    cyc(0, 0, 0, 1);
    chk("resume_38", got(2), pack(3, 8, 1, 0, 0));

    // mid-RUN asynchronous reset
    cyc(0, 0, 0, 1);
    async_reset();

    // randomized commands and lever against the model
    for (int i = 0; i < 4000; i++) begin
      bit s, p, c, l;
      c = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 9) == 0) ? ~lever : lever;
      if ($urandom_range(0, 799) == 0) async_reset();
      cyc(s, p, c, l);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
